// File: rtl/wb_dual_master_arbiter_if.sv
// Wishbone classic bus bundle shared by the two masters and the slave.
// 'master' is the view of whoever drives the bus; 'slave' is the view of
// whoever answers it. err only exists on the slave-facing side.
interface wb_dual_master_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [DW/8-1:0] sel;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic            ack;
    logic            err;

    // Handshake: a transfer is requested while cyc & stb are high and
    // completes in the cycle where ack (or err) is high; cyc framing a
    // bus cycle may span several strobes.
    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_dual_master_arbiter.sv
// Two-master Wishbone arbiter with round-robin or fixed priority, grant held
// for the whole cyc, and a watchdog that ends hung accesses with err.
module wb_dual_master_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TIMEOUT    = 255,
    parameter int FIXED_PRIO = 0
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    wb_dual_master_arbiter_if.slave  m0_bus,
    wb_dual_master_arbiter_if.slave  m1_bus,
    wb_dual_master_arbiter_if.master s_bus,
    output logic [1:0]             gnt_o,
    output logic                   timeout_o,
    output logic [1:0]             state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);
    localparam bit          PRIO_M0   = (FIXED_PRIO != 0);

    state_t          state_q, state_d;
    logic            last_owner_q, last_owner_d;  // 0 = m0, 1 = m1
    logic            owner_q, owner_d;            // owner remembered for DRAIN
    logic [15:0]     wdog_q, wdog_d;

    logic            req0, req1, pick_m1;
    logic            in_own, expire, drain_cyc;
    logic            own_cyc, own_stb, own_we;
    logic [DW/8-1:0] own_sel;
    logic [AW-1:0]   own_adr;
    logic [DW-1:0]   own_dat;

    assign req0      = m0_bus.cyc & m0_bus.stb;
    assign req1      = m1_bus.cyc & m1_bus.stb;
    // Round-robin hands a tie to whoever did not own the bus last.
    assign pick_m1   = !PRIO_M0 && !last_owner_q;
    assign in_own    = (state_q == OWN0) || (state_q == OWN1);
    assign drain_cyc = owner_q ? m1_bus.cyc : m0_bus.cyc;
    // Ack in the expiry cycle wins, so expiry requires ack low.
    assign expire    = in_own && own_cyc && own_stb && !s_bus.ack &&
                       (wdog_q == WDOG_LAST);

    // Slave side: owner's signals pass through; expiry kills cyc/stb at once.
    assign s_bus.cyc   = own_cyc & ~expire;
    assign s_bus.stb   = own_stb & ~expire;
    assign s_bus.we    = own_we;
    assign s_bus.sel   = own_sel;
    assign s_bus.adr   = own_adr;
    assign s_bus.dat_w = own_dat;

    // Master side: read data is broadcast; ack/err only reach the owner.
    assign m0_bus.dat_r = s_bus.dat_r;
    assign m1_bus.dat_r = s_bus.dat_r;
    assign m0_bus.ack   = (state_q == OWN0) & s_bus.ack;
    assign m1_bus.ack   = (state_q == OWN1) & s_bus.ack;
    assign m0_bus.err   = (state_q == OWN0) & expire;
    assign m1_bus.err   = (state_q == OWN1) & expire;
    assign timeout_o    = expire;
    assign state_o      = state_q;

    // Owner mux: only a granted master reaches the slave bus.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_sel = '0;
        own_adr = '0;
        own_dat = '0;
        case (state_q)
            OWN0: begin
                own_cyc = m0_bus.cyc;
                own_stb = m0_bus.stb;
                own_we  = m0_bus.we;
                own_sel = m0_bus.sel;
                own_adr = m0_bus.adr;
                own_dat = m0_bus.dat_w;
            end
            OWN1: begin
                own_cyc = m1_bus.cyc;
                own_stb = m1_bus.stb;
                own_we  = m1_bus.we;
                own_sel = m1_bus.sel;
                own_adr = m1_bus.adr;
                own_dat = m1_bus.dat_w;
            end
            default: begin
            end
        endcase
    end

    // Grant indicator: owner stays flagged through DRAIN until it lets go.
    always_comb begin
        gnt_o = 2'b00;
        case (state_q)
            OWN0:    gnt_o = 2'b01;
            OWN1:    gnt_o = 2'b10;
            DRAIN:   gnt_o = owner_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    // Next-state logic: arbitration, grant hold, watchdog and drain.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        wdog_d       = '0;
        case (state_q)
            IDLE: begin
                if (req0 && !(req1 && pick_m1)) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                owner_d = (state_q == OWN1);
                if (!own_cyc) begin
                    state_d      = IDLE;
                    last_owner_d = (state_q == OWN1);
                end else if (expire) begin
                    state_d = DRAIN;
                end else if (own_stb && !s_bus.ack) begin
                    wdog_d = 16'(wdog_q + 16'd1);
                end
            end
            DRAIN: begin
                if (!drain_cyc) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; last_owner resets to m1 so m0 wins the first tie.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            wdog_q       <= wdog_d;
        end
    end

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Directed bench for wb_dual_master_arbiter: a round-robin instance and a
// fixed-priority instance (both TIMEOUT=8) share the same stimulus.
module tb_wb_dual_master_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    logic        m0_cyc, m0_stb, m0_we;
    logic [3:0]  m0_sel;
    logic [31:0] m0_adr, m0_dat;
    logic        m1_cyc, m1_stb, m1_we;
    logic [3:0]  m1_sel;
    logic [31:0] m1_adr, m1_dat;
    logic        s_ack;
    logic [31:0] s_dat;

    int checks = 0;
    int errors = 0;

    wb_dual_master_arbiter_if #(.AW(32), .DW(32)) m0_rr();
    wb_dual_master_arbiter_if #(.AW(32), .DW(32)) m1_rr();
    wb_dual_master_arbiter_if #(.AW(32), .DW(32)) s_rr();
    wb_dual_master_arbiter_if #(.AW(32), .DW(32)) m0_fp();
    wb_dual_master_arbiter_if #(.AW(32), .DW(32)) m1_fp();
    wb_dual_master_arbiter_if #(.AW(32), .DW(32)) s_fp();

    logic [1:0] gnt_rr, gnt_fp, st_rr, st_fp;
    logic       to_rr, to_fp;

    assign m0_rr.cyc = m0_cyc;  assign m0_fp.cyc = m0_cyc;
    assign m0_rr.stb = m0_stb;  assign m0_fp.stb = m0_stb;
    assign m0_rr.we  = m0_we;   assign m0_fp.we  = m0_we;
    assign m0_rr.sel = m0_sel;  assign m0_fp.sel = m0_sel;
    assign m0_rr.adr = m0_adr;  assign m0_fp.adr = m0_adr;
    assign m0_rr.dat_w = m0_dat; assign m0_fp.dat_w = m0_dat;
    assign m1_rr.cyc = m1_cyc;  assign m1_fp.cyc = m1_cyc;
    assign m1_rr.stb = m1_stb;  assign m1_fp.stb = m1_stb;
    assign m1_rr.we  = m1_we;   assign m1_fp.we  = m1_we;
    assign m1_rr.sel = m1_sel;  assign m1_fp.sel = m1_sel;
    assign m1_rr.adr = m1_adr;  assign m1_fp.adr = m1_adr;
    assign m1_rr.dat_w = m1_dat; assign m1_fp.dat_w = m1_dat;
    assign s_rr.ack = s_ack;    assign s_fp.ack = s_ack;
    assign s_rr.dat_r = s_dat;  assign s_fp.dat_r = s_dat;
    assign s_rr.err = 1'b0;     assign s_fp.err = 1'b0;

    wb_dual_master_arbiter #(.AW(32), .DW(32), .TIMEOUT(8), .FIXED_PRIO(0)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .m0_bus   (m0_rr),
        .m1_bus   (m1_rr),
        .s_bus    (s_rr),
        .gnt_o    (gnt_rr),
        .timeout_o(to_rr),
        .state_o  (st_rr)
    );

    wb_dual_master_arbiter #(.AW(32), .DW(32), .TIMEOUT(8), .FIXED_PRIO(1)) dut_fp (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .m0_bus   (m0_fp),
        .m1_bus   (m1_fp),
        .s_bus    (s_fp),
        .gnt_o    (gnt_fp),
        .timeout_o(to_fp),
        .state_o  (st_fp)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, ...
    always #5 clk = ~clk;

    // Inputs change 1 unit after the rising edge; checks follow a short settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 0; m0_adr = 0; m0_dat = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 0; m1_adr = 0; m1_dat = 0;
        s_ack = 0; s_dat = 0;

        // Reset values
        tick(); tick();
        check("rst_gnt", 32'(gnt_rr), 32'h0);
        check("rst_state", 32'(st_rr), 32'h0);
        check("rst_s_cyc", 32'(s_rr.cyc), 32'h0);
        check("rst_s_adr", s_rr.adr, 32'h0);
        check("rst_timeout", 32'(to_rr), 32'h0);
        check("rst_m0_ack", 32'(m0_rr.ack), 32'h0);
        #4 rst_n = 1'b1;
        tick();

        // Simultaneous requests x8: rr alternates m0,m1; fixed prio always m0
        for (int i = 0; i < 8; i++) begin
            m0_cyc = 1; m0_stb = 1; m0_adr = 32'h1000 + 32'(i);
            m1_cyc = 1; m1_stb = 1; m1_adr = 32'h2000 + 32'(i);
            #1;
            check("arb_decision_s_cyc", 32'(s_rr.cyc), 32'h0);
            tick();
            check("rr_gnt", 32'(gnt_rr), (i % 2 == 0) ? 32'h1 : 32'h2);
            check("fp_gnt", 32'(gnt_fp), 32'h1);
            check("rr_s_adr", s_rr.adr, (i % 2 == 0) ? 32'h1000 + 32'(i) : 32'h2000 + 32'(i));
            s_ack = 1;
            #1;
            check("rr_m0_ack", 32'(m0_rr.ack), (i % 2 == 0) ? 32'h1 : 32'h0);
            check("rr_m1_ack", 32'(m1_rr.ack), (i % 2 == 0) ? 32'h0 : 32'h1);
            tick();
            s_ack = 0;
            m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
            tick();
        end

        // Single m0 read at 0x3000_0004, ack two cycles after stb
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_sel = 4'hF; m0_adr = 32'h3000_0004;
        #1;
        check("rd_decision_gnt", 32'(gnt_rr), 32'h0);
        check("rd_decision_s_cyc", 32'(s_rr.cyc), 32'h0);
        tick();
        check("rd_gnt", 32'(gnt_rr), 32'h1);
        check("rd_s_cyc", 32'(s_rr.cyc), 32'h1);
        check("rd_s_stb", 32'(s_rr.stb), 32'h1);
        check("rd_s_adr", s_rr.adr, 32'h3000_0004);
        check("rd_s_sel", 32'(s_rr.sel), 32'hF);
        check("rd_m0_ack_wait", 32'(m0_rr.ack), 32'h0);
        tick(); tick();
        s_ack = 1; s_dat = 32'hDEAD_BEEF;
        #1;
        check("rd_m0_ack", 32'(m0_rr.ack), 32'h1);
        check("rd_m0_dat", m0_rr.dat_r, 32'hDEAD_BEEF);
        check("rd_m1_ack", 32'(m1_rr.ack), 32'h0);
        check("rd_m1_err", 32'(m1_rr.err), 32'h0);
        tick();
        s_ack = 0;
        #1;
        check("rd_m0_ack_copy", 32'(m0_rr.ack), 32'h0);
        m0_cyc = 0; m0_stb = 0;
        #1;
        check("rd_drop_s_cyc", 32'(s_rr.cyc), 32'h0);
        check("rd_drop_gnt", 32'(gnt_rr), 32'h1);
        tick();
        check("rd_idle_gnt", 32'(gnt_rr), 32'h0);
        check("rd_idle_state", 32'(st_rr), 32'h0);

        // m1 4-beat write burst with m0 requesting meanwhile
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'hF; m1_adr = 32'h100; m1_dat = 32'hA0;
        tick();
        check("bu_gnt", 32'(gnt_rr), 32'h2);
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h999;
        for (int k = 0; k < 4; k++) begin
            m1_adr = 32'h100 + 32'(4 * k);
            m1_dat = 32'hA0 + 32'(k);
            s_ack = 1;
            #1;
            check("bu_s_stb", 32'(s_rr.stb), 32'h1);
            check("bu_s_adr", s_rr.adr, 32'h100 + 32'(4 * k));
            check("bu_s_dat", s_rr.dat_w, 32'hA0 + 32'(k));
            check("bu_s_we", 32'(s_rr.we), 32'h1);
            check("bu_m1_ack", 32'(m1_rr.ack), 32'h1);
            check("bu_m0_ack", 32'(m0_rr.ack), 32'h0);
            check("bu_gnt_hold", 32'(gnt_rr), 32'h2);
            tick();
        end
        m1_cyc = 0; m1_stb = 0; m1_we = 0; s_ack = 0;
        #1;
        check("bu_drop_s_cyc", 32'(s_rr.cyc), 32'h0);
        check("bu_drop_gnt", 32'(gnt_rr), 32'h2);
        tick();
        check("bu_decision_gnt", 32'(gnt_rr), 32'h0);
        tick();
        check("bu_m0_gnt", 32'(gnt_rr), 32'h1);
        check("bu_m0_adr", s_rr.adr, 32'h999);
        s_ack = 1;
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick();

        // Watchdog expiry: slave never acks m0
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h40;
        tick();
        for (int c = 1; c < 8; c++) begin
            check("wd_err_early", 32'(m0_rr.err), 32'h0);
            check("wd_s_cyc_early", 32'(s_rr.cyc), 32'h1);
            tick();
        end
        check("wd_m0_err", 32'(m0_rr.err), 32'h1);
        check("wd_timeout", 32'(to_rr), 32'h1);
        check("wd_s_cyc_kill", 32'(s_rr.cyc), 32'h0);
        check("wd_s_stb_kill", 32'(s_rr.stb), 32'h0);
        check("wd_m1_err", 32'(m1_rr.err), 32'h0);
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h55;
        tick();
        s_ack = 1;
        #1;
        check("dr_state", 32'(st_rr), 32'h3);
        check("dr_m0_ack", 32'(m0_rr.ack), 32'h0);
        check("dr_m1_ack", 32'(m1_rr.ack), 32'h0);
        check("dr_err_pulse", 32'(m0_rr.err), 32'h0);
        check("dr_timeout_pulse", 32'(to_rr), 32'h0);
        check("dr_s_cyc", 32'(s_rr.cyc), 32'h0);
        tick();
        s_ack = 0;
        check("dr_hold", 32'(st_rr), 32'h3);
        m0_cyc = 0; m0_stb = 0;
        tick();
        check("dr_idle_gnt", 32'(gnt_rr), 32'h0);
        tick();
        check("dr_m1_gnt", 32'(gnt_rr), 32'h2);
        check("dr_m1_adr", s_rr.adr, 32'h55);
        s_ack = 1;
        tick();
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        tick();

        // Ack landing exactly on the 8th strobe cycle wins over expiry
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h80;
        tick();
        for (int c = 1; c < 8; c++) tick();
        s_ack = 1;
        #1;
        check("ae_m0_ack", 32'(m0_rr.ack), 32'h1);
        check("ae_m0_err", 32'(m0_rr.err), 32'h0);
        check("ae_timeout", 32'(to_rr), 32'h0);
        check("ae_s_cyc", 32'(s_rr.cyc), 32'h1);
        tick();
        s_ack = 0;
        check("ae_state_own0", 32'(st_rr), 32'h1);
        m0_cyc = 0; m0_stb = 0;
        tick();

        // Asynchronous reset in the middle of an m1 access
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h77;
        tick();
        check("ar_gnt_before", 32'(gnt_rr), 32'h2);
        s_ack = 1;
        #1;
        check("ar_m1_ack_before", 32'(m1_rr.ack), 32'h1);
        rst_n = 1'b0;
        #1;
        check("ar_s_cyc", 32'(s_rr.cyc), 32'h0);
        check("ar_gnt", 32'(gnt_rr), 32'h0);
        check("ar_m1_ack", 32'(m1_rr.ack), 32'h0);
        check("ar_state", 32'(st_rr), 32'h0);
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        #3 rst_n = 1'b1;
        tick();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        tick();
        check("ar_first_tie_m0", 32'(gnt_rr), 32'h1);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_dual_master_arbiter.md
Name: wb_dual_master_arbiter

Overview:
- Shares the user project's single Wishbone slave bus between two masters.
- m0 is the management SoC Wishbone (wbs_* from the wrapper). m1 is a logic-analyzer-driven master built from la_data_in bits.
- Arbitration is round-robin or fixed-priority. The grant is held for the whole bus cycle (cyc), including bursts.
- A watchdog terminates hung slave accesses with an error.

Parameters:
AW, 32, address width
DW, 32, data width (multiple of 8)
TIMEOUT, 255, cycles of s_stb_o high without s_ack_i before error termination (1..65535)
FIXED_PRIO, 0, 0 = round-robin, 1 = m0 always wins simultaneous requests

Ports:
wb_clk_i  in  1  bus clock
wb_rst_ni  in  1  asynchronous active-low reset
m0_cyc_i / m1_cyc_i  in  1  master cycle request
m0_stb_i / m1_stb_i  in  1  master strobe
m0_we_i / m1_we_i  in  1  write enable
m0_sel_i / m1_sel_i  in  DW/8  byte selects
m0_adr_i / m1_adr_i  in  AW  address
m0_dat_i / m1_dat_i  in  DW  write data
m0_dat_o / m1_dat_o  out  DW  read data (s_dat_i broadcast)
m0_ack_o / m1_ack_o  out  1  ack to master
m0_err_o / m1_err_o  out  1  timeout error to master
s_cyc_o, s_stb_o, s_we_o  out  1  slave control
s_sel_o  out  DW/8  slave byte selects
s_adr_o  out  AW  slave address
s_dat_o  out  DW  slave write data
s_dat_i  in  DW  slave read data
s_ack_i  in  1  slave ack
gnt_o  out  2  one-hot current owner (bit0 = m0, bit1 = m1), 00 when idle
timeout_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Clocking and reset: one clock, wb_clk_i. Reset wb_rst_ni is asynchronous and active-low.
- Reset values:
  - state = IDLE, gnt_o = 00, last_owner = m1 (so m0 wins the first contention).
  - Watchdog counter = 0.
  - All s_* control outputs, ack_o, err_o and timeout_o = 0.
  - Address, data and sel outputs = 0.
- A request from master X is mX_cyc_i & mX_stb_i.
- States: IDLE, OWN0, OWN1, DRAIN.
- IDLE:
  - On a request, register the grant: next state OWN0 or OWN1.
  - Arbitration latency is exactly 1 cycle; no slave signal is driven in the decision cycle.
  - On simultaneous requests: round-robin grants the master that is not last_owner; FIXED_PRIO=1 grants m0.
- OWNx:
  - mux: s_cyc/stb/we/sel/adr/dat are combinational copies of the owner's inputs.
  - s_ack_i routes combinationally to mX_ack_o. The non-owner's ack and err stay 0.
  - m0_dat_o = m1_dat_o = s_dat_i at all times.
  - The grant is held while mX_cyc_i = 1, so multiple strobes or a burst stay with the owner.
  - Owner drops cyc (even mid-access, without ack): s_cyc_o falls the same cycle via the mux, last_owner = X, next state IDLE. That master's re-request competes in IDLE like any other.
  - A non-owner request is held off; it never preempts.
- Watchdog:
  - Counts cycles with s_stb_o = 1 & s_ack_i = 0 in OWNx. It clears on s_ack_i, on s_stb_o = 0, and on leaving OWNx.
  - When the count reaches TIMEOUT-1 and s_ack_i = 0, that cycle: mX_err_o = 1, timeout_o = 1, s_cyc_o = s_stb_o = 0 are forced.
  - Next state is DRAIN.
  - If s_ack_i coincides with expiry, the ack wins: no err, counter clears.
- DRAIN:
  - s_cyc_o = 0.
  - Wait for the owner's mX_cyc_i = 0, then set last_owner = X and go to IDLE.
  - Any slave ack arriving in DRAIN is discarded; no ack is forwarded.
- Reset asserted mid-access forces reset values immediately, without waiting for a clock edge.

Test Plan:
- Single m0 read at 0x3000_0004, slave acks 2 cycles after s_stb_o -> gnt_o = 01 one cycle after request; m0_ack_o is a copy of s_ack_i; m0_dat_o = 0xDEAD_BEEF; back to IDLE after cyc drops; m1 outputs stay 0.
- m0 and m1 request in the same cycle, repeated 4 transactions each -> grants alternate m0, m1, m0, m1 (FIXED_PRIO=0); with FIXED_PRIO=1, m0 wins every contention.
- m1 holds cyc for a 4-beat write burst while m0 requests -> all 4 s_stb_o beats carry m1 adr/dat; m0 is granted only the cycle after m1 drops cyc.
- TIMEOUT=8, slave never acks -> m0_err_o and timeout_o pulse once on the 8th stb cycle; s_cyc_o = 0 from that cycle; DRAIN until m0 drops cyc; the next m1 request is served.
- TIMEOUT=8, s_ack_i arrives exactly on the 8th cycle -> ack delivered, no err, no timeout_o.
- Assert wb_rst_ni low mid-OWN1 between clock edges -> s_cyc_o, gnt_o and m1_ack_o go 0 immediately. After release, simultaneous requests grant m0 first.
